// File: rtl/otter_mdu_pkg.sv
// Shared types and constants for the OTTER iterative multiply/divide sequencer.
package otter_mdu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    ITER,
    FIX,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_t;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_PASS  = 4'b1001;
  localparam logic [4:0] ITER_LAST = 5'd31;

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is treated as signed for MULH, DIV and REM.
  function automatic logic op_signed_b(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/otter_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer; every add, subtract and negate
// goes through the shared OTTER ALU over a fixed 36-cycle schedule.
module otter_mdu_seq
  import otter_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      alu_fun,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("otter_mdu_seq supports only XLEN=32");
  end

  state_t          state;
  mdu_op_t         op;
  logic [XLEN-1:0] orig_a;
  logic [XLEN-1:0] orig_b;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] hi;       // product high word / remainder
  logic [XLEN-1:0] lo;       // product low word / quotient
  logic [4:0]      cnt;

  logic            is_div;
  logic            is_rem;
  logic [XLEN-1:0] sh;
  logic            div_take;
  logic            mul_carry;
  logic            fix_neg;
  logic [XLEN-1:0] fix_word;

  // Per-step decisions: divide shift/compare, multiply carry, final sign fix.
  always_comb begin
    is_div    = op[2];
    is_rem    = op[2] & op[1];
    sh        = {hi[XLEN-2:0], lo[XLEN-1]};
    div_take  = hi[XLEN-1] | (sh >= b_abs);
    mul_carry = (alu_result < hi);
    if (is_div)
      fix_word = is_rem ? hi : lo;
    else
      fix_word = (op == OP_MUL) ? lo : hi;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV: fix_neg = sign_a ^ sign_b;
      OP_REM:                     fix_neg = sign_a;
      default:                    fix_neg = 1'b0;
    endcase
  end

  // ALU request for the current state; PASS 0 whenever the ALU is not ours.
  always_comb begin
    alu_fun = ALU_PASS;
    alu_a   = '0;
    alu_b   = '0;
    case (state)
      NEG_A: begin
        alu_fun = sign_a ? ALU_SUB : ALU_PASS;
        alu_a   = sign_a ? '0 : orig_a;
        alu_b   = sign_a ? orig_a : '0;
      end
      NEG_B: begin
        alu_fun = sign_b ? ALU_SUB : ALU_PASS;
        alu_a   = sign_b ? '0 : orig_b;
        alu_b   = sign_b ? orig_b : '0;
      end
      ITER: begin
        if (is_div) begin
          alu_fun = ALU_SUB;
          alu_a   = sh;
          alu_b   = b_abs;
        end else begin
          alu_fun = lo[0] ? ALU_ADD : ALU_PASS;
          alu_a   = hi;
          alu_b   = lo[0] ? a_abs : '0;
        end
      end
      FIX: begin
        if (fix_neg && is_div) begin
          alu_fun = ALU_SUB;
          alu_b   = fix_word;
        end else if (fix_neg) begin
          // High word of the 64-bit negation: ~hi plus the carry out of ~lo+1.
          alu_fun = ALU_ADD;
          alu_a   = ~hi;
          alu_b   = {{(XLEN-1){1'b0}}, (lo == '0)};
        end else begin
          alu_a   = fix_word;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      op     <= OP_MUL;
      orig_a <= '0;
      orig_b <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_abs  <= '0;
      b_abs  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op     <= mdu_op_t'(funct3);
            orig_a <= rs1;
            orig_b <= rs2;
            sign_a <= rs1[XLEN-1] & op_signed_a(mdu_op_t'(funct3));
            sign_b <= rs2[XLEN-1] & op_signed_b(mdu_op_t'(funct3));
            busy   <= 1'b1;
            state  <= NEG_A;
          end
        end
        NEG_A: begin
          a_abs <= alu_result;
          state <= NEG_B;
        end
        NEG_B: begin
          b_abs <= alu_result;
          hi    <= '0;
          lo    <= is_div ? a_abs : alu_result;
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          if (is_div) begin
            hi <= div_take ? alu_result : sh;
            lo <= {lo[XLEN-2:0], div_take};
          end else begin
            {hi, lo} <= {mul_carry, alu_result, lo[XLEN-1:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == ITER_LAST) state <= FIX;
        end
        FIX: begin
          if (is_div && (b_abs == '0))
            result <= is_rem ? orig_a : '1;
          else
            result <= alu_result;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
